// File: rtl/conv_pixel_engine.sv
// Per-pixel convolution engine: int8 MAC over TAPS terms, bias, optional leaky ReLU, requantize to int8.
// Optional build macro CONV_PIXEL_ENGINE_SAT_CNT_EN adds a saturation event counter output (sat_count).
module conv_pixel_engine #(
  parameter int TAPS    = 27,
  parameter int NUM_OCH = 32,
  parameter int ACC_W   = 32,
  parameter int SCALE_Q = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 scale,
  input  logic                        leaky_en,
  input  logic                        tap_valid,
  output logic                        tap_ready,
  input  logic signed [7:0]           tap_weight,
  input  logic signed [7:0]           tap_act,
  input  logic signed [ACC_W-1:0]     bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [7:0]           out_data,
  output logic [$clog2(NUM_OCH)-1:0]  out_ch,
  output logic                        out_last,
`ifdef CONV_PIXEL_ENGINE_SAT_CNT_EN
  output logic [15:0]                 sat_count,
`endif
  output logic                        busy
);

  localparam int CH_W  = $clog2(NUM_OCH);
  localparam int TAP_W = $clog2(TAPS + 1);
  localparam int QW    = ACC_W + 17;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACCUM = 3'd1;
  localparam logic [2:0] BIAS  = 3'd2;
  localparam logic [2:0] ACT   = 3'd3;
  localparam logic [2:0] QUANT = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  localparam logic signed [QW-1:0] Q_RND = QW'(1) <<< (SCALE_Q - 1);
  localparam logic signed [QW-1:0] Q_MAX = QW'(127);
  localparam logic signed [QW-1:0] Q_MIN = QW'(-128);

  logic [2:0]              state;
  logic [CH_W-1:0]         ch;
  logic [TAP_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_q;
  logic [15:0]             scale_q;
  logic                    leaky_q;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [QW-1:0]    q_full;
  logic signed [QW-1:0]    q_shift;
  logic                    q_hi;
  logic                    q_lo;
  logic signed [7:0]       q_byte;

  assign prod     = tap_weight * tap_act;
  assign prod_ext = ACC_W'(prod);

  // The product of an ACC_W value and a 17-bit non-negative scale always fits in QW bits.
  assign q_full  = QW'(acc) * QW'($signed({1'b0, scale_q}));
  assign q_shift = (q_full + Q_RND) >>> SCALE_Q;
  assign q_hi    = q_shift > Q_MAX;
  assign q_lo    = q_shift < Q_MIN;
  assign q_byte  = q_hi ? 8'sd127 : (q_lo ? -8'sd128 : q_shift[7:0]);

  assign tap_ready = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign out_ch    = ch;
  assign out_last  = (state == OUT) && (ch == CH_W'(NUM_OCH - 1));

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      tap_cnt  <= '0;
      acc      <= '0;
      bias_q   <= '0;
      scale_q  <= '0;
      leaky_q  <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            ch      <= '0;
            tap_cnt <= '0;
            acc     <= '0;
            scale_q <= scale;
            leaky_q <= leaky_en;
          end
        end
        ACCUM: begin
          if (tap_valid) begin
            acc <= acc + prod_ext;
            if (tap_cnt == '0) bias_q <= bias;
            if (tap_cnt == TAP_W'(TAPS - 1)) begin
              tap_cnt <= '0;
              state   <= BIAS;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
            end
          end
        end
        BIAS: begin
          acc   <= acc + bias_q;
          state <= ACT;
        end
        ACT: begin
          if (leaky_q && acc[ACC_W-1]) acc <= acc >>> 3;
          state <= QUANT;
        end
        QUANT: begin
          out_data <= q_byte;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (ch == CH_W'(NUM_OCH - 1)) begin
              state <= IDLE;
            end else begin
              ch      <= ch + 1'b1;
              tap_cnt <= '0;
              acc     <= '0;
              state   <= ACCUM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_PIXEL_ENGINE_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (state == IDLE && start) begin
      sat_count <= '0;
    end else if (state == QUANT && (q_hi || q_lo) && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
